// File: rtl/decode_stage.sv
// decode_stage: combinational instruction decode plus a 32x64 register file.
// Decodes the supported ARM-style subset into a 14-bit control word, register
// selects, immediate and branch target, and provides two combinational read
// ports. Optional build macro DECODE_WRITE_BYPASS_EN forwards the write-back
// data onto a read port whose address matches the register being written.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken,
    input  logic [63:0] if_PC,
    input  logic [31:0] if_instruction,
    input  logic        RegWrite_final,
    input  logic [4:0]  write_reg_final,
    input  logic [63:0] write_data_final,
    output logic [63:0] PC_offset,
    output logic [63:0] reg_data1,
    output logic [63:0] reg_data2,
    output logic [63:0] imm_ext,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [4:0]  reg2,
    output logic [13:0] control_signals,
    output logic        id_branch_taken,
    output logic [63:0] id_branch_target
);

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_EOR   = 3'b011;
    localparam logic [2:0] ALU_LSR   = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;

    logic [63:0] r_regs [0:31];

    logic               w_addi, w_adds, w_subs, w_and, w_eor, w_lsr;
    logic               w_ldur, w_stur, w_br, w_b, w_bl, w_blt, w_cbz;
    logic [13:0]        w_ctrl;
    logic [4:0]         w_rd;
    logic               w_reg2loc;
    logic [63:0]        w_imm;
    logic signed [63:0] w_br_off;
    logic [63:0]        w_rdata1;
    logic [63:0]        w_rdata2;

    // Branch displacements are word offsets, so they are scaled by 4.
    function automatic logic signed [63:0] sext_word26(input logic [25:0] v);
        return {{36{v[25]}}, v, 2'b00};
    endfunction

    function automatic logic signed [63:0] sext_word19(input logic [18:0] v);
        return {{43{v[18]}}, v, 2'b00};
    endfunction

    function automatic logic signed [63:0] sext9(input logic [8:0] v);
        return {{55{v[8]}}, v};
    endfunction

    assign w_addi = (if_instruction[31:22] == 10'b1001000100);
    assign w_adds = (if_instruction[31:21] == 11'b10101011000);
    assign w_subs = (if_instruction[31:21] == 11'b11101011000);
    assign w_and  = (if_instruction[31:21] == 11'b10001010000);
    assign w_eor  = (if_instruction[31:21] == 11'b11001010000);
    assign w_lsr  = (if_instruction[31:21] == 11'b11010011010);
    assign w_ldur = (if_instruction[31:21] == 11'b11111000010);
    assign w_stur = (if_instruction[31:21] == 11'b11111000000);
    assign w_br   = (if_instruction[31:21] == 11'b11010110000);
    assign w_b    = (if_instruction[31:26] == 6'b000101);
    assign w_bl   = (if_instruction[31:26] == 6'b100101);
    assign w_blt  = (if_instruction[31:24] == 8'b01010100) && (if_instruction[4:0] == 5'b01011);
    assign w_cbz  = (if_instruction[31:24] == 8'b10110100);

    // Control word; opcodes are mutually exclusive, unknown encodings stay all-zero.
    always_comb begin
        w_ctrl = '0;
        if (w_addi) begin
            w_ctrl[13] = 1'b1; w_ctrl[9] = 1'b1; w_ctrl[8:6] = ALU_ADD;
        end else if (w_adds) begin
            w_ctrl[13] = 1'b1; w_ctrl[8:6] = ALU_ADD; w_ctrl[2] = 1'b1;
        end else if (w_subs) begin
            w_ctrl[13] = 1'b1; w_ctrl[8:6] = ALU_SUB; w_ctrl[2] = 1'b1;
        end else if (w_and) begin
            w_ctrl[13] = 1'b1; w_ctrl[8:6] = ALU_AND;
        end else if (w_eor) begin
            w_ctrl[13] = 1'b1; w_ctrl[8:6] = ALU_EOR;
        end else if (w_lsr) begin
            w_ctrl[13] = 1'b1; w_ctrl[9] = 1'b1; w_ctrl[8:6] = ALU_LSR;
        end else if (w_ldur) begin
            w_ctrl[13] = 1'b1; w_ctrl[11] = 1'b1; w_ctrl[10] = 1'b1;
            w_ctrl[9]  = 1'b1; w_ctrl[8:6] = ALU_ADD;
        end else if (w_stur) begin
            w_ctrl[12] = 1'b1; w_ctrl[9] = 1'b1; w_ctrl[8:6] = ALU_ADD; w_ctrl[5] = 1'b1;
        end else if (w_br) begin
            w_ctrl[1] = 1'b1;
        end else if (w_bl) begin
            w_ctrl[13] = 1'b1; w_ctrl[0] = 1'b1;
        end else if (w_blt) begin
            w_ctrl[4] = 1'b1;
        end else if (w_cbz) begin
            w_ctrl[8:6] = ALU_PASSB; w_ctrl[5] = 1'b1; w_ctrl[3] = 1'b1;
        end
    end

    assign w_reg2loc = w_stur | w_cbz;
    assign w_rd      = w_bl ? 5'd30 : (w_ctrl[13] ? if_instruction[4:0] : 5'd31);

    // Immediate extension per instruction format.
    always_comb begin
        w_imm = '0;
        if (w_addi)
            w_imm = {52'b0, if_instruction[21:10]};
        else if (w_ldur || w_stur)
            w_imm = sext9(if_instruction[20:12]);
        else if (w_lsr)
            w_imm = {58'b0, if_instruction[15:10]};
    end

    // Branch displacement; non-branches add nothing so PC_offset falls back to if_PC.
    always_comb begin
        w_br_off = '0;
        if (w_b || w_bl)
            w_br_off = sext_word26(if_instruction[25:0]);
        else if (w_blt || w_cbz)
            w_br_off = sext_word19(if_instruction[23:5]);
    end

    assign PC_offset        = if_PC + $unsigned(w_br_off);
    assign id_branch_target = PC_offset;
    assign imm_ext          = w_imm;
    assign rs1              = if_instruction[9:5];
    assign rs2              = if_instruction[20:16];
    assign reg2             = w_reg2loc ? if_instruction[4:0] : if_instruction[20:16];
    // A flush squashes the instruction into a bubble.
    assign control_signals  = branch_taken ? 14'd0 : w_ctrl;
    assign rd               = branch_taken ? 5'd31 : w_rd;
    assign id_branch_taken  = w_b & ~branch_taken;

    // Register storage: async clear, X31 never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= '0;
        end else if (RegWrite_final && (write_reg_final != 5'd31)) begin
            r_regs[write_reg_final] <= write_data_final;
        end
    end

    // Combinational read ports with X31 hardwired to zero.
    always_comb begin
        w_rdata1 = (rs1 == 5'd31) ? 64'd0 : r_regs[rs1];
        w_rdata2 = (reg2 == 5'd31) ? 64'd0 : r_regs[reg2];
`ifdef DECODE_WRITE_BYPASS_EN
        // Forward only writes that will actually land (not to X31, not in reset).
        if (reset && RegWrite_final && (write_reg_final != 5'd31)) begin
            if (write_reg_final == rs1)
                w_rdata1 = write_data_final;
            if (write_reg_final == reg2)
                w_rdata2 = write_data_final;
        end
`endif
    end

    assign reg_data1 = w_rdata1;
    assign reg_data2 = w_rdata2;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// mnemonic-level reference model and an array model of the register file.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_taken;
    logic [63:0] if_PC;
    logic [31:0] if_instruction;
    logic        RegWrite_final;
    logic [4:0]  write_reg_final;
    logic [63:0] write_data_final;
    logic [63:0] PC_offset, reg_data1, reg_data2, imm_ext, id_branch_target;
    logic [4:0]  rs1, rs2, rd, reg2;
    logic [13:0] control_signals;
    logic        id_branch_taken;

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] m_regs [32];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(rst_n), .branch_taken(branch_taken), .if_PC(if_PC),
        .if_instruction(if_instruction), .RegWrite_final(RegWrite_final),
        .write_reg_final(write_reg_final), .write_data_final(write_data_final),
        .PC_offset(PC_offset), .reg_data1(reg_data1), .reg_data2(reg_data2),
        .imm_ext(imm_ext), .rs1(rs1), .rs2(rs2), .rd(rd), .reg2(reg2),
        .control_signals(control_signals), .id_branch_taken(id_branch_taken),
        .id_branch_target(id_branch_target)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic string mnem(input logic [31:0] i);
        if (i[31:22] == 10'b1001000100) return "ADDI";
        if (i[31:21] == 11'b10101011000) return "ADDS";
        if (i[31:21] == 11'b11101011000) return "SUBS";
        if (i[31:21] == 11'b10001010000) return "AND";
        if (i[31:21] == 11'b11001010000) return "EOR";
        if (i[31:21] == 11'b11010011010) return "LSR";
        if (i[31:21] == 11'b11111000010) return "LDUR";
        if (i[31:21] == 11'b11111000000) return "STUR";
        if (i[31:21] == 11'b11010110000) return "BR";
        if (i[31:26] == 6'b000101) return "B";
        if (i[31:26] == 6'b100101) return "BL";
        if (i[31:24] == 8'b01010100 && i[4:0] == 5'b01011) return "BLT";
        if (i[31:24] == 8'b10110100) return "CBZ";
        return "NONE";
    endfunction

    function automatic logic [13:0] row(input bit rw, mw, mr, m2r, src, input int op,
                                        input bit r2l, cb, cbz, sf, br, bl);
        logic [2:0] o;
        o = 3'(op);
        return {rw, mw, mr, m2r, src, o, r2l, cb, cbz, sf, br, bl};
    endfunction

    function automatic logic [13:0] ctrl_of(input string m);
        if (m == "ADDI") return row(1,0,0,0,1,0,0,0,0,0,0,0);
        if (m == "ADDS") return row(1,0,0,0,0,0,0,0,0,1,0,0);
        if (m == "SUBS") return row(1,0,0,0,0,1,0,0,0,1,0,0);
        if (m == "AND")  return row(1,0,0,0,0,2,0,0,0,0,0,0);
        if (m == "EOR")  return row(1,0,0,0,0,3,0,0,0,0,0,0);
        if (m == "LSR")  return row(1,0,0,0,1,4,0,0,0,0,0,0);
        if (m == "LDUR") return row(1,0,1,1,1,0,0,0,0,0,0,0);
        if (m == "STUR") return row(0,1,0,0,1,0,1,0,0,0,0,0);
        if (m == "BR")   return row(0,0,0,0,0,0,0,0,0,0,1,0);
        if (m == "BL")   return row(1,0,0,0,0,0,0,0,0,0,0,1);
        if (m == "BLT")  return row(0,0,0,0,0,0,0,1,0,0,0,0);
        if (m == "CBZ")  return row(0,0,0,0,0,5,1,0,1,0,0,0);
        return 14'd0;
    endfunction

    function automatic logic [63:0] exp_read(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
`ifdef DECODE_WRITE_BYPASS_EN
        if (rst_n && RegWrite_final && write_reg_final != 5'd31 && write_reg_final == a)
            return write_data_final;
`endif
        return m_regs[a];
    endfunction

    task automatic chk_decode(input string tag);
        string       m;
        logic [13:0] c;
        logic [4:0]  erd, ereg2;
        logic [63:0] eimm, epco;
        logic        ebrt;
        longint      off;
        int          v;
        m     = mnem(if_instruction);
        c     = ctrl_of(m);
        erd   = (m == "BL") ? 5'd30 : (c[13] ? if_instruction[4:0] : 5'd31);
        ereg2 = c[5] ? if_instruction[4:0] : if_instruction[20:16];
        eimm  = 64'd0;
        if (m == "ADDI") eimm = 64'(if_instruction[21:10]);
        if (m == "LSR")  eimm = 64'(if_instruction[15:10]);
        if (m == "LDUR" || m == "STUR") begin
            v = int'(if_instruction[20:12]);
            if (v >= 256) v -= 512;
            eimm = 64'(longint'(v));
        end
        off = 0;
        if (m == "B" || m == "BL") begin
            off = longint'(if_instruction[25:0]);
            if (off >= 2**25) off -= 2**26;
        end else if (m == "BLT" || m == "CBZ") begin
            off = longint'(if_instruction[23:5]);
            if (off >= 2**18) off -= 2**19;
        end
        epco = if_PC + 64'(off * 4);
        ebrt = (m == "B");
        if (branch_taken) begin
            c = 14'd0; erd = 5'd31; ebrt = 1'b0;
        end
        chk({tag, ".ctrl"},   64'(control_signals), 64'(c));
        chk({tag, ".rd"},     64'(rd), 64'(erd));
        chk({tag, ".rs1"},    64'(rs1), 64'(if_instruction[9:5]));
        chk({tag, ".rs2"},    64'(rs2), 64'(if_instruction[20:16]));
        chk({tag, ".reg2"},   64'(reg2), 64'(ereg2));
        chk({tag, ".imm"},    imm_ext, eimm);
        chk({tag, ".pcoff"},  PC_offset, epco);
        chk({tag, ".target"}, id_branch_target, epco);
        chk({tag, ".brtk"},   64'(id_branch_taken), 64'(ebrt));
        chk({tag, ".rdata1"}, reg_data1, exp_read(if_instruction[9:5]));
        chk({tag, ".rdata2"}, reg_data2, exp_read(ereg2));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && RegWrite_final && write_reg_final != 5'd31)
            m_regs[write_reg_final] = write_data_final;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr(input int k);
        logic [31:0] r;
        r = $urandom;
        case (k)
            0:  return {10'b1001000100, r[21:0]};
            1:  return {11'b10101011000, r[20:0]};
            2:  return {11'b11101011000, r[20:0]};
            3:  return {11'b10001010000, r[20:0]};
            4:  return {11'b11001010000, r[20:0]};
            5:  return {11'b11010011010, r[20:0]};
            6:  return {11'b11111000010, r[20:0]};
            7:  return {11'b11111000000, r[20:0]};
            8:  return {11'b11010110000, r[20:0]};
            9:  return {6'b000101, r[25:0]};
            10: return {6'b100101, r[25:0]};
            11: return {8'b01010100, r[23:5], 5'b01011};
            12: return {8'b10110100, r[23:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        rst_n = 1'b0; branch_taken = 1'b0; if_PC = 64'd0; if_instruction = 32'd0;
        RegWrite_final = 1'b1; write_reg_final = 5'd3; write_data_final = 64'hDEAD;

        // Reset held: every register reads zero and writes are blocked.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if_instruction = {11'b10101011000, 5'(i), 6'd0, 5'(i), 5'd1};
            #1;
            chk($sformatf("rst.x%0d.r1", i), reg_data1, 64'd0);
            chk($sformatf("rst.x%0d.r2", i), reg_data2, 64'd0);
        end

        // First write after release lands on the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        if_instruction = {11'b10101011000, 5'd3, 6'd0, 5'd3, 5'd1};
        #1 chk_decode("release.pre");
        tick();
        RegWrite_final = 1'b0;
        #1 chk("release.x3", reg_data1, 64'hDEAD);

        // Write X5 and attempt X31, then ADDS X1,X5,X31.
        RegWrite_final = 1'b1; write_reg_final = 5'd5; write_data_final = 64'h1234;
        tick();
        write_reg_final = 5'd31; write_data_final = 64'hFF;
        tick();
        RegWrite_final = 1'b0;
        if_instruction = {11'b10101011000, 5'd31, 6'd0, 5'd5, 5'd1};
        #1;
        chk("adds.r1", reg_data1, 64'h1234);
        chk("adds.r2", reg_data2, 64'd0);
        chk("adds.rw", 64'(control_signals[13]), 64'd1);
        chk("adds.sf", 64'(control_signals[2]), 64'd1);
        chk("adds.rd", 64'(rd), 64'd1);
        chk_decode("adds");

        // B -2 at 0x100, then flushed.
        @(negedge clk);
        if_PC = 64'h100; if_instruction = {6'b000101, 26'h3FFFFFE};
        #1;
        chk("b.taken", 64'(id_branch_taken), 64'd1);
        chk("b.target", id_branch_target, 64'hF8);
        chk_decode("b");
        branch_taken = 1'b1;
        #1;
        chk("bflush.taken", 64'(id_branch_taken), 64'd0);
        chk("bflush.ctrl", 64'(control_signals), 64'd0);
        chk_decode("bflush");
        branch_taken = 1'b0;

        // LDUR X2,[X3,#-8] and STUR X4,[X3,#16].
        @(negedge clk);
        if_instruction = {11'b11111000010, 9'h1F8, 2'b00, 5'd3, 5'd2};
        #1;
        chk("ldur.imm", imm_ext, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("ldur.mr", 64'(control_signals[11]), 64'd1);
        chk("ldur.m2r", 64'(control_signals[10]), 64'd1);
        chk("ldur.rd", 64'(rd), 64'd2);
        chk_decode("ldur");
        if_instruction = {11'b11111000000, 9'd16, 2'b00, 5'd3, 5'd4};
        #1;
        chk("stur.reg2", 64'(reg2), 64'd4);
        chk("stur.rd", 64'(rd), 64'd31);
        chk("stur.mw", 64'(control_signals[12]), 64'd1);
        chk_decode("stur");

        // BL +4 words at 0x40.
        @(negedge clk);
        if_PC = 64'h40; if_instruction = {6'b100101, 26'd4};
        #1;
        chk("bl.rd", 64'(rd), 64'd30);
        chk("bl.bl", 64'(control_signals[0]), 64'd1);
        chk("bl.pcoff", PC_offset, 64'h50);
        chk("bl.taken", 64'(id_branch_taken), 64'd0);
        chk_decode("bl");

        // Same-cycle write and read of X7.
        RegWrite_final = 1'b1; write_reg_final = 5'd7; write_data_final = 64'h55;
        tick();
        if_instruction = {11'b10101011000, 5'd7, 6'd0, 5'd7, 5'd1};
        write_data_final = 64'hAA;
        #1;
`ifdef DECODE_WRITE_BYPASS_EN
        chk("byp.pre", reg_data1, 64'hAA);
`else
        chk("byp.pre", reg_data1, 64'h55);
`endif
        chk_decode("byp");
        tick();
        RegWrite_final = 1'b0;
        #1 chk("byp.post", reg_data1, 64'hAA);

        // Randomized instructions, flushes and write-back traffic.
        for (int n = 0; n < 300; n++) begin
            if_instruction   = rand_instr(int'($urandom_range(0, 13)));
            if_PC            = {$urandom, $urandom};
            branch_taken     = ($urandom_range(0, 3) == 0);
            RegWrite_final   = $urandom_range(0, 1) == 1;
            write_reg_final  = ($urandom_range(0, 2) == 0) ? if_instruction[9:5]
                                                           : 5'($urandom_range(0, 31));
            write_data_final = {$urandom, $urandom};
            #1 chk_decode($sformatf("rand%0d", n));
            tick();
        end

        // Asynchronous reset mid-cycle clears storage without a clock edge.
        RegWrite_final = 1'b0;
        if_instruction = {11'b10101011000, 5'd7, 6'd0, 5'd5, 5'd1};
        #2 rst_n = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        #1;
        chk("arst.r1", reg_data1, 64'd0);
        chk("arst.r2", reg_data2, 64'd0);
        RegWrite_final = 1'b1; write_reg_final = 5'd5; write_data_final = 64'h77;
        tick();
        #1 chk("arst.blocked", reg_data1, 64'd0);
        RegWrite_final = 1'b0;
        rst_n = 1'b1;
        #1 chk_decode("arst.after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
